data_memory_ctrl: RTL and testbench
===================================

Name: data_memory_ctrl

Overview:
Parametrised single-port data memory for the calculator datapath, the successor of the fixed 512x16 data RAM. Adds a valid/ready request interface, a registered read with a response-valid strobe, and an out-of-range address flag. A hardware clear sequencer zeroes every location after reset or on command. It sits between the control unit and operand/result storage.

Parameters:
DATA_W, 16, data word width in bits (signed two's complement)
ADDR_W, 9, address width in bits
DEPTH, 512, number of implemented words; must satisfy 1 <= DEPTH <= 2**ADDR_W

Ports:
CLK  input  1  clock; all state updates on rising edge
RST  input  1  asynchronous, active-low reset
req_valid  input  1  request present
req_ready  output  1  block accepts a request this cycle
req_we  input  1  1 = write, 0 = read
req_addr  input  ADDR_W  word address
req_wdata  input  DATA_W  signed write data
rsp_valid  output  1  read data valid (one-cycle pulse)
rsp_rdata  output  DATA_W  signed read data, held between responses
clr_start  input  1  request a full clear (sampled in IDLE only)
busy  output  1  clear sequence in progress
err_oob  output  1  one-cycle pulse: accepted request had req_addr >= DEPTH

Behaviour:
- Clock and reset: one clock (CLK). Reset is asynchronous and active-low (RST).
- While RST = 0: state = CLEAR, clear counter = 0, req_ready = 0, busy = 1, rsp_valid = 0, rsp_rdata = 0, err_oob = 0. The array contents are not reset.
- FSM states: CLEAR and IDLE.
- CLEAR:
  - Each cycle, write 0 to address clr_cnt, then increment clr_cnt.
  - After the write to DEPTH-1, move to IDLE.
  - With RST released, the clear takes exactly DEPTH rising edges; busy = 1 throughout.
  - req_ready = 0; requests are neither accepted nor queued.
- IDLE:
  - busy = 0 and req_ready = 1.
  - Accept a request when req_valid && req_ready.
  - If clr_start = 1 and req_valid = 0: go to CLEAR with clr_cnt = 0 on the next edge.
  - If clr_start = 1 and req_valid = 1 in the same cycle: the request is accepted first. CLEAR starts on that same edge, so req_ready drops on the next cycle.
- Write accept:
  - RAM[req_addr] <= req_wdata on the accepting edge.
  - No response; rsp_valid stays 0.
- Read accept:
  - rsp_rdata = RAM[req_addr] and rsp_valid = 1 in the cycle after acceptance (latency 1, registered).
  - rsp_rdata holds its value until the next read response.
  - Back-to-back reads give one response per cycle.
- Read after write, same address, consecutive cycles: the read returns the newly written value.
- Out of range (req_addr >= DEPTH, only possible when DEPTH < 2**ADDR_W):
  - Write: dropped.
  - Read: rsp_valid = 1 with rsp_rdata = 0.
  - err_oob = 1 for one cycle, aligned with the cycle where the response would appear.
- Reset during CLEAR: the counter restarts at 0 after release, and a full DEPTH-cycle clear runs again.
- Reset in IDLE: any pending response is discarded (rsp_valid = 0).
- No combinational path from req_* to rsp_*.

Decomposition:
- Shared package:
  - DATA_W/ADDR_W default constants
  - FSM state enum {ST_CLEAR, ST_IDLE}
  - zero-word constant
- One sub-module, sram_1rw (DATA_W, ADDR_W, DEPTH):
  - plain synchronous single-port array, one write port and one registered read port, no reset
  - the controller muxes the clear address/zero data onto its write port while in CLEAR

Test Plan:
1. Reset clear: pulse RST low, release; count edges -> busy = 1 for exactly 512 cycles, then req_ready = 1; reading addresses 0, 255, 511 returns 0.
2. Write/read: write 0x7FFF @5 and 0x8000 (-32768) @6, then read 5 and 6 -> rsp_valid one cycle after each read; rdata = 32767 then -32768.
3. Read-after-write: write 0x1234 @100 then read @100 on the next cycle -> rsp_rdata = 0x1234 one cycle later.
4. clr_start: fill 0..3 with nonzero, pulse clr_start -> busy for 512 cycles, req_ready = 0 meanwhile; subsequent reads of 0..3 return 0.
5. Reset mid-clear: assert RST at clr_cnt = 200, release -> busy lasts a full 512 cycles after release.
6. DEPTH = 300, ADDR_W = 9: write 0x55AA @310 then read @310 -> err_oob pulses once per request, read returns 0; reads of 0..299 are unaffected.

Source files
------------

// File: rtl/data_memory_ctrl_pkg.sv
// Shared definitions for the data memory controller and its storage array.
package data_memory_ctrl_pkg;

    localparam int DATA_W_DEF = 16;
    localparam int ADDR_W_DEF = 9;

    localparam logic [DATA_W_DEF-1:0] ZERO_WORD = '0;

    typedef enum logic {
        ST_CLEAR = 1'b0,
        ST_IDLE  = 1'b1
    } state_t;

endpackage

// File: rtl/data_memory_ctrl_sram_1rw.sv
// Plain single-port synchronous array: one write port, one registered read
// port sharing the address. No reset; the read register only updates on i_re
// so the last read word is held.
module sram_1rw #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 9,
    parameter int DEPTH  = 512
) (
    input  logic              i_clk,
    input  logic              i_we,
    input  logic              i_re,
    input  logic [ADDR_W-1:0] i_addr,
    input  logic [DATA_W-1:0] i_wdata,
    output logic [DATA_W-1:0] o_rdata
);

    logic [DATA_W-1:0] r_mem [DEPTH];
    logic [DATA_W-1:0] r_rdata;

    // Array write and registered read; the caller never asserts both at once.
    always_ff @(posedge i_clk) begin
        if (i_we) begin
            r_mem[i_addr] <= i_wdata;
        end
        if (i_re) begin
            r_rdata <= r_mem[i_addr];
        end
    end

    assign o_rdata = r_rdata;

endmodule

// File: rtl/data_memory_ctrl.sv
// Data memory controller: valid/ready request port in front of a single-port
// array, registered read response, out-of-range flag, and a clear sequencer
// that zeroes every word after reset or on command.
//
// state    | meaning
// ST_CLEAR | writing zero to r_clr_cnt each cycle; requests refused
// ST_IDLE  | accepting read/write requests
module data_memory_ctrl
    import data_memory_ctrl_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DEPTH  = 512
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              rsp_valid,
    output logic [DATA_W-1:0] rsp_rdata,
    input  logic              clr_start,
    output logic              busy,
    output logic              err_oob
);

    // DEPTH may equal 2**ADDR_W, so the range compare needs one extra bit.
    localparam logic [ADDR_W:0]   LP_DEPTH_EXT = (ADDR_W+1)'(DEPTH);
    localparam logic [ADDR_W-1:0] LP_LAST_ADDR = ADDR_W'(DEPTH - 1);

    state_t            r_state;
    state_t            w_state_nxt;
    logic [ADDR_W-1:0] r_clr_cnt;
    logic [ADDR_W-1:0] w_clr_cnt_nxt;

    logic              r_rsp_valid;
    logic              r_err_oob;
    logic              r_rd_zero;

    logic              w_oob;
    logic              w_accept;
    logic              w_ram_we;
    logic              w_ram_re;
    logic [ADDR_W-1:0] w_ram_addr;
    logic [DATA_W-1:0] w_ram_wdata;
    logic [DATA_W-1:0] w_ram_rdata;

    assign w_oob = ({1'b0, req_addr} >= LP_DEPTH_EXT);

    // State and clear-counter registers.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            r_state   <= ST_CLEAR;
            r_clr_cnt <= '0;
        end else begin
            r_state   <= w_state_nxt;
            r_clr_cnt <= w_clr_cnt_nxt;
        end
    end

    // Next state, clear sequencing, request acceptance and array port mux.
    always_comb begin
        w_state_nxt   = r_state;
        w_clr_cnt_nxt = r_clr_cnt;
        req_ready     = 1'b0;
        busy          = 1'b0;
        w_accept      = 1'b0;
        w_ram_we      = 1'b0;
        w_ram_re      = 1'b0;
        w_ram_addr    = req_addr;
        w_ram_wdata   = req_wdata;
        case (r_state)
            ST_CLEAR: begin
                busy        = 1'b1;
                // No array writes while reset is held; contents are not reset.
                w_ram_we    = RST;
                w_ram_addr  = r_clr_cnt;
                w_ram_wdata = DATA_W'(ZERO_WORD);
                if (r_clr_cnt == LP_LAST_ADDR) begin
                    w_state_nxt   = ST_IDLE;
                    w_clr_cnt_nxt = '0;
                end else begin
                    w_clr_cnt_nxt = r_clr_cnt + 1'b1;
                end
            end
            ST_IDLE: begin
                req_ready = 1'b1;
                w_accept  = req_valid;
                if (req_valid && !w_oob) begin
                    w_ram_we = req_we;
                    w_ram_re = !req_we;
                end
                // A request in the same cycle is served before the clear begins.
                if (clr_start) begin
                    w_state_nxt   = ST_CLEAR;
                    w_clr_cnt_nxt = '0;
                end
            end
            default: begin
                w_state_nxt   = ST_CLEAR;
                w_clr_cnt_nxt = '0;
            end
        endcase
    end

    // Response strobe, error strobe and zero-data select for the held read word.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            r_rsp_valid <= 1'b0;
            r_err_oob   <= 1'b0;
            r_rd_zero   <= 1'b1;
        end else begin
            r_rsp_valid <= w_accept && !req_we;
            r_err_oob   <= w_accept && w_oob;
            if (w_accept && !req_we) begin
                r_rd_zero <= w_oob;
            end
        end
    end

    sram_1rw #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W),
        .DEPTH  (DEPTH)
    ) u_sram (
        .i_clk   (CLK),
        .i_we    (w_ram_we),
        .i_re    (w_ram_re),
        .i_addr  (w_ram_addr),
        .i_wdata (w_ram_wdata),
        .o_rdata (w_ram_rdata)
    );

    assign rsp_valid = r_rsp_valid;
    assign rsp_rdata = r_rd_zero ? '0 : w_ram_rdata;
    assign err_oob   = r_err_oob;

endmodule

// File: tb/tb_data_memory_ctrl.sv
// Bench: two controllers (DEPTH 512 and DEPTH 300) driven by the same request
// stream, each compared against a simple array model of its memory.
module tb_data_memory_ctrl;

    logic        CLK = 1'b0;
    logic        RST;
    logic        req_valid;
    logic        req_we;
    logic [8:0]  req_addr;
    logic [15:0] req_wdata;
    logic        clr_start;

    logic        a_ready, a_rsp_valid, a_busy, a_err_oob;
    logic [15:0] a_rdata;
    logic        b_ready, b_rsp_valid, b_busy, b_err_oob;
    logic [15:0] b_rdata;

    int checks = 0;
    int errors = 0;

    logic [15:0] mem_a [512];
    logic [15:0] mem_b [300];
    logic [15:0] last_a;
    logic [15:0] last_b;

    always #5 CLK = ~CLK;

    data_memory_ctrl #(.DATA_W(16), .ADDR_W(9), .DEPTH(512)) dut_a (
        .CLK(CLK), .RST(RST), .req_valid(req_valid), .req_ready(a_ready),
        .req_we(req_we), .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(a_rsp_valid), .rsp_rdata(a_rdata), .clr_start(clr_start),
        .busy(a_busy), .err_oob(a_err_oob)
    );

    data_memory_ctrl #(.DATA_W(16), .ADDR_W(9), .DEPTH(300)) dut_b (
        .CLK(CLK), .RST(RST), .req_valid(req_valid), .req_ready(b_ready),
        .req_we(req_we), .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(b_rsp_valid), .rsp_rdata(b_rdata), .clr_start(clr_start),
        .busy(b_busy), .err_oob(b_err_oob)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_clear();
        for (int i = 0; i < 512; i++) mem_a[i] = '0;
        for (int i = 0; i < 300; i++) mem_b[i] = '0;
    endtask

    // One request cycle: drive at negedge, check the registered outcome after the edge.
    task automatic step(input bit v, input bit we, input logic [8:0] a,
                        input logic [15:0] d, input bit clr);
        @(negedge CLK);
        req_valid = v; req_we = we; req_addr = a; req_wdata = d; clr_start = clr;
        if (v) begin
            chk("ready_a", a_ready, 1);
            chk("ready_b", b_ready, 1);
        end
        if (v && we) begin
            mem_a[a] = d;
            if (a < 300) mem_b[a] = d;
        end
        if (v && !we) begin
            last_a = mem_a[a];
            last_b = (a < 300) ? mem_b[a] : 16'h0000;
        end
        @(posedge CLK);
        #1;
        chk("rsp_valid_a", a_rsp_valid, v && !we);
        chk("rsp_valid_b", b_rsp_valid, v && !we);
        chk("rdata_a", a_rdata, last_a);
        chk("rdata_b", b_rdata, last_b);
        chk("err_oob_a", a_err_oob, 0);
        chk("err_oob_b", b_err_oob, v && (a >= 300));
        chk("busy_a", a_busy, clr);
        chk("busy_b", b_busy, clr);
        if (clr) model_clear();
        req_valid = 1'b0; req_we = 1'b0; clr_start = 1'b0;
    endtask

    // Count edges from the start of a clear until busy drops, for both instances.
    task automatic measure_clear(input string tag);
        int n = 0;
        int na = -1;
        int nb = -1;
        bit rdy_in_busy = 1'b0;
        while ((na < 0 || nb < 0) && n < 2000) begin
            @(posedge CLK);
            #1;
            n++;
            if (na < 0 && !a_busy) na = n;
            if (nb < 0 && !b_busy) nb = n;
            if ((a_busy && a_ready) || (b_busy && b_ready)) rdy_in_busy = 1'b1;
        end
        chk({tag, "_len_a"}, na, 512);
        chk({tag, "_len_b"}, nb, 300);
        chk({tag, "_ready_in_busy"}, rdy_in_busy, 0);
        chk({tag, "_ready_after_a"}, a_ready, 1);
        chk({tag, "_ready_after_b"}, b_ready, 1);
    endtask

    initial begin
        logic [8:0]  lw;
        logic [8:0]  ra;
        logic [15:0] rd;
        bit          rv;
        bit          rw;

        RST = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_addr = '0;
        req_wdata = '0; clr_start = 1'b0;
        last_a = '0; last_b = '0; lw = '0;
        model_clear();

        // Reset values
        repeat (3) @(posedge CLK);
        #1;
        chk("rst_busy", a_busy, 1);
        chk("rst_ready", a_ready, 0);
        chk("rst_rsp_valid", a_rsp_valid, 0);
        chk("rst_rdata", a_rdata, 0);
        chk("rst_err_oob", a_err_oob, 0);
        @(negedge CLK);
        RST = 1'b1;
        measure_clear("por");

        // Cleared contents, including the top address (out of range for DEPTH 300)
        step(1, 0, 9'd0, 16'h0, 0);
        step(1, 0, 9'd255, 16'h0, 0);
        step(1, 0, 9'd511, 16'h0, 0);

        // Extreme signed values and hold of rdata across writes
        step(1, 1, 9'd5, 16'h7FFF, 0);
        step(1, 1, 9'd6, 16'h8000, 0);
        step(1, 0, 9'd5, 16'h0, 0);
        step(1, 0, 9'd6, 16'h0, 0);
        step(0, 0, 9'd0, 16'h0, 0);

        // Read immediately after write to the same address
        step(1, 1, 9'd100, 16'h1234, 0);
        step(1, 0, 9'd100, 16'h0, 0);

        // Commanded clear
        for (int i = 0; i < 4; i++) step(1, 1, 9'(i), 16'(16'hA5A0 + i), 0);
        step(0, 0, 9'd0, 16'h0, 1);
        measure_clear("cmd");
        for (int i = 0; i < 4; i++) step(1, 0, 9'(i), 16'h0, 0);

        // Reset in the middle of a clear restarts it from zero
        step(0, 0, 9'd0, 16'h0, 1);
        repeat (200) @(posedge CLK);
        @(negedge CLK);
        RST = 1'b0;
        #1;
        chk("midclr_busy", a_busy, 1);
        chk("midclr_ready", a_ready, 0);
        @(negedge CLK);
        RST = 1'b1;
        measure_clear("midclr");

        // Out-of-range on the 300-word instance, in range on the 512-word one
        step(1, 1, 9'd310, 16'h55AA, 0);
        step(1, 0, 9'd310, 16'h0, 0);
        step(1, 0, 9'd299, 16'h0, 0);

        // Read accepted in the same cycle as a clear command
        step(1, 1, 9'd7, 16'hBEEF, 0);
        step(1, 0, 9'd7, 16'h0, 1);
        measure_clear("clrrd");
        step(1, 0, 9'd7, 16'h0, 0);

        // Randomized traffic against the array model
        for (int i = 0; i < 400; i++) begin
            rv = ($urandom_range(0, 3) != 0);
            rw = $urandom_range(0, 1) == 1;
            ra = 9'($urandom_range(0, 511));
            if (!rw && $urandom_range(0, 3) == 0) ra = lw;
            rd = 16'($urandom);
            if (rv && rw) lw = ra;
            step(rv, rw, ra, rd, 0);
        end

        // Reset in IDLE drops a pending response
        @(negedge CLK);
        req_valid = 1'b1; req_we = 1'b0; req_addr = lw;
        @(posedge CLK);
        #1;
        chk("pend_rsp_valid", a_rsp_valid, 1);
        req_valid = 1'b0;
        RST = 1'b0;
        #1;
        chk("rstidle_rsp_valid", a_rsp_valid, 0);
        chk("rstidle_rdata", a_rdata, 0);
        chk("rstidle_rsp_valid_b", b_rsp_valid, 0);
        last_a = '0; last_b = '0;
        model_clear();
        @(negedge CLK);
        RST = 1'b1;
        measure_clear("rstidle");
        step(1, 0, lw, 16'h0, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
